bcd_digit_collector: RTL and testbench

BCD_DIGIT_COLLECTOR -- requirements
Module: bcd_digit_collector

---
 rtl/bcd_digit_collector.sv | 98 +++++++++
 tb/tb_bcd_digit_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_collector.sv
// rtl/bcd_digit_collector.sv - debounced keypad digit collector (four BCD digits)
module bcd_digit_collector #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  bcd,
  input  logic        valid_data,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        entry_full,
  output logic        new_digit,
  output logic        rejected,
  output logic        time_ok
);

  typedef enum logic {IDLE, HELD} state_t;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  count_q, count_d;
  logic        new_q, new_d;
  logic        rej_q, rej_d;
  logic        full_q, full_d;
  logic        tok_q, tok_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= '0;
      count_q  <= '0;
      new_q    <= 1'b0;
      rej_q    <= 1'b0;
      full_q   <= 1'b0;
      tok_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      new_q    <= new_d;
      rej_q    <= rej_d;
      full_q   <= full_d;
      tok_q    <= tok_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    count_d  = count_q;
    new_d    = 1'b0;
    rej_d    = 1'b0;
    if (clear) begin
      // A key still held through clear must be released before it can count again.
      digits_d = '0;
      count_d  = '0;
      cnt_d    = '0;
      state_d  = valid_data ? HELD : IDLE;
    end else if (state_q == IDLE) begin
      if (!enable || !valid_data) begin
        cnt_d = '0;
      end else if (cnt_q >= DB_LAST) begin
        state_d = HELD;
        cnt_d   = '0;
        if (bcd <= 4'd9 && count_q < 3'd4) begin
          digits_d = {digits_q[11:0], bcd};
          count_d  = count_q + 3'd1;
          new_d    = 1'b1;
        end else begin
          rej_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = '0;
      if (!valid_data) state_d = IDLE;
    end
    full_d = (count_d == 3'd4);
    tok_d  = (count_d != 3'd0) && (digits_d[7:4] <= 4'd5);
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign entry_full  = full_q;
  assign new_digit   = new_q;
  assign rejected    = rej_q;
  assign time_ok     = tok_q;

endmodule

// File: tb/tb_bcd_digit_collector.sv
// tb/tb_bcd_digit_collector.sv - scoreboard bench for bcd_digit_collector
module tb_bcd_digit_collector;

  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bcd;
  logic        valid_data;
  logic        enable;
  logic        clear;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        entry_full;
  logic        new_digit;
  logic        rejected;
  logic        time_ok;

  bcd_digit_collector #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .bcd(bcd), .valid_data(valid_data),
    .enable(enable), .clear(clear), .digits(digits), .digit_count(digit_count),
    .entry_full(entry_full), .new_digit(new_digit), .rejected(rejected),
    .time_ok(time_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_new;
    logic [15:0] d;
    int          c;
    bit          f;
    bit          t;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_digits;
  int          m_count;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_tok();
    return (m_count > 0) && (m_digits[7:4] <= 4'd5);
  endfunction

  task automatic model_eval(input logic [3:0] k, input int at);
    exp_t e;
    if (k <= 4'd9 && m_count < 4) begin
      m_digits = {m_digits[11:0], k};
      m_count++;
      e.is_new = 1'b1;
    end else begin
      e.is_new = 1'b0;
    end
    e.d  = m_digits;
    e.c  = m_count;
    e.f  = (m_count == 4);
    e.t  = m_tok();
    e.at = at;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (new_digit || rejected)) begin
      chk("pulse_exclusive", int'(new_digit & rejected), 0);
      chk("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_new", int'(new_digit), int'(e.is_new));
        chk("pulse_digits", int'(digits), int'(e.d));
        chk("pulse_count", int'(digit_count), e.c);
        chk("pulse_full", int'(entry_full), int'(e.f));
        chk("pulse_time_ok", int'(time_ok), int'(e.t));
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_digits"}, int'(digits), int'(m_digits));
    chk({tag, "_count"}, int'(digit_count), m_count);
    chk({tag, "_full"}, int'(entry_full), int'(m_count == 4));
    chk({tag, "_time_ok"}, int'(time_ok), int'(m_tok()));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digits"}, int'(digits), 0);
    chk({tag, "_count"}, int'(digit_count), 0);
    chk({tag, "_full"}, int'(entry_full), 0);
    chk({tag, "_new"}, int'(new_digit), 0);
    chk({tag, "_rej"}, int'(rejected), 0);
    chk({tag, "_time_ok"}, int'(time_ok), 0);
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    int t0;
    @(posedge clk); #1;
    bcd = k;
    valid_data = 1'b1;
    t0 = cyc;
    if (hold >= DB && enable) model_eval(k, t0 + DB);
    repeat (hold) @(posedge clk);
    #1 valid_data = 1'b0;
    repeat (rel) @(posedge clk);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    m_digits = '0;
    m_count  = 0;
  endtask

  initial begin
    int t;
    reset = 1'b1; bcd = '0; valid_data = 1'b0; enable = 1'b1; clear = 1'b0;
    m_digits = '0; m_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    press(4'd1, 5, 3); press(4'd2, 5, 3); press(4'd3, 5, 3); press(4'd0, 5, 3);
    check_state("full_1230");

    press(4'd9, 5, 3);
    check_state("rej9");
    do_clear();
    check_state("clr1");
    press(4'hC, 5, 3);
    check_state("rejC");

    // single-sample glitch must not reach the scoreboard
    @(posedge clk); #1 bcd = 4'd7; valid_data = 1'b1;
    @(posedge clk); #1 valid_data = 1'b0;
    repeat (3) @(posedge clk);
    check_state("glitch");
    press(4'd7, 10, 3);
    check_state("held7");

    do_clear();
    press(4'd0, 5, 3); press(4'd7, 5, 3);
    check_state("s0007");
    press(4'd0, 5, 3);
    check_state("s0070");

    // clear lands on the capture edge of key 5
    @(posedge clk); #1 bcd = 4'd5; valid_data = 1'b1;
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    m_digits = '0; m_count = 0;
    repeat (5) @(posedge clk);
    check_state("clr_capture");
    @(posedge clk); #1 valid_data = 1'b0;
    repeat (3) @(posedge clk);
    press(4'd5, 5, 3);
    check_state("after_clr5");

    @(posedge clk); #1 enable = 1'b0; bcd = 4'd4; valid_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    t = cyc;
    model_eval(4'd4, t + DB);
    repeat (5) @(posedge clk);
    #1 valid_data = 1'b0;
    repeat (3) @(posedge clk);
    check_state("enable4");

    @(posedge clk); #1 bcd = 4'd6; valid_data = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    t = cyc;
    m_digits = '0; m_count = 0;
    model_eval(4'd6, t + DB);
    @(negedge clk);
    check_zero("mid_reset");
    repeat (5) @(posedge clk);
    #1 valid_data = 1'b0;
    repeat (3) @(posedge clk);
    check_state("reset6");

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
